// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_pkg
// Description : Shared encodings for the multi-cycle control unit: FSM state
//               codes, opcode map, ALU function codes, instruction classes
//               and the packed datapath control vector.
// Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

  localparam int OPW    = 6;   // opcode width, instr[31:26]
  localparam int ALUOPW = 4;   // ALU function select width
  localparam int STW    = 3;   // state register width

  // FSM state encoding (state_o exposes these values directly)
  localparam logic [STW-1:0] S_FETCH  = 3'd0;
  localparam logic [STW-1:0] S_DECODE = 3'd1;
  localparam logic [STW-1:0] S_EXEC   = 3'd2;
  localparam logic [STW-1:0] S_MEM    = 3'd3;
  localparam logic [STW-1:0] S_WB     = 3'd4;
  localparam logic [STW-1:0] S_HALT   = 3'd7;

  // Opcode map; I-ALU and branch are matched on their prefixes
  localparam logic [OPW-1:0] OP_RALU     = 6'b000000;
  localparam logic [2:0]     OP_IALU_PFX = 3'b001;
  localparam logic [OPW-1:0] OP_LD       = 6'b010000;
  localparam logic [OPW-1:0] OP_ST       = 6'b010001;
  localparam logic [3:0]     OP_BR_PFX   = 4'b0101;
  localparam logic [OPW-1:0] OP_JMP      = 6'b011000;
  localparam logic [OPW-1:0] OP_CALL     = 6'b011001;
  localparam logic [OPW-1:0] OP_RET      = 6'b011010;
  localparam logic [OPW-1:0] OP_PUSH     = 6'b011011;
  localparam logic [OPW-1:0] OP_POP      = 6'b011100;
  localparam logic [OPW-1:0] OP_MOVE     = 6'b011101;
  localparam logic [OPW-1:0] OP_HALT     = 6'b111111;

  // ALU function codes driven by the control unit itself
  localparam logic [ALUOPW-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUOPW-1:0] ALU_SUB = 4'b0001;

  // Branch condition codes carried in opcode bits [1:0]
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_Z    = 2'b01,
    BR_PL   = 2'b10,
    BR_MI   = 2'b11
  } branch_e;

  // Instruction classes after opcode decode
  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_IALU, C_LD, C_ST, C_BR, C_JMP,
    C_CALL, C_RET, C_PUSH, C_POP, C_MOVE, C_HALT
  } iclass_e;

  // Complete per-cycle datapath control vector
  typedef struct packed {
    logic              pc_update;
    logic              reg_dest;
    logic              write_sp;
    logic              read_sp;
    logic              update_sp;
    logic              write_reg;
    logic              alu_source;
    logic              pm4;
    logic              spmmux;
    logic              ret_mem;
    logic              mem_read;
    logic              mem_write;
    logic              mem_reg;
    logic              spmux;
    logic              move_reg;
    logic              jump;
    logic              ret_pc;
    logic              halt_pc;
    logic              halted;
    logic [1:0]        branch;
    logic [ALUOPW-1:0] alu_op;
  } ctrl_t;

  // Map an opcode to its instruction class; unlisted codes are NOPs
  function automatic iclass_e classify(input logic [OPW-1:0] op);
    iclass_e cls;
    cls = C_NOP;
    if (op == OP_RALU) begin
      cls = C_RALU;
    end else if (op[5:3] == OP_IALU_PFX) begin
      cls = C_IALU;
    end else if (op[5:2] == OP_BR_PFX) begin
      // a zero condition field is not a branch
      cls = (op[1:0] != BR_NONE) ? C_BR : C_NOP;
    end else begin
      case (op)
        OP_LD:   cls = C_LD;
        OP_ST:   cls = C_ST;
        OP_JMP:  cls = C_JMP;
        OP_CALL: cls = C_CALL;
        OP_RET:  cls = C_RET;
        OP_PUSH: cls = C_PUSH;
        OP_POP:  cls = C_POP;
        OP_MOVE: cls = C_MOVE;
        OP_HALT: cls = C_HALT;
        default: cls = C_NOP;
      endcase
    end
    return cls;
  endfunction

  // Classes that need a MEM step between EXEC and WB
  function automatic logic uses_mem(input iclass_e cls);
    return (cls == C_LD)  || (cls == C_ST)   || (cls == C_CALL) ||
           (cls == C_RET) || (cls == C_PUSH) || (cls == C_POP);
  endfunction

endpackage : control_pkg
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_decode
// Description : Purely combinational control decoder. Maps a state and the
//               opcode/funct fields of the held instruction to the datapath
//               control vector for that state.
// Revision    : 1.0 - initial release
// ============================================================================
module control_decode
  import control_pkg::*;
(
  input  logic [STW-1:0]    state_i,
  input  logic [OPW-1:0]    op_i,
  input  logic [ALUOPW-1:0] funct_i,
  output ctrl_t             ctrl_o
);

  iclass_e cls;
  logic    sp_dn;   // PUSH/CALL: stack grows down (SP-1)
  logic    sp_up;   // POP/RET: stack shrinks (SP+1)
  logic    sp_op;

  assign cls   = classify(op_i);
  assign sp_dn = (cls == C_PUSH) || (cls == C_CALL);
  assign sp_up = (cls == C_POP)  || (cls == C_RET);
  assign sp_op = sp_dn || sp_up;

  // Build the control vector for the requested state
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH, S_DECODE: begin
        ctrl_o.halt_pc = 1'b1;
      end

      S_EXEC: begin
        ctrl_o.halt_pc = 1'b1;
        case (cls)
          C_RALU: begin
            ctrl_o.alu_source = 1'b1;
            ctrl_o.reg_dest   = 1'b1;
            ctrl_o.alu_op     = funct_i;
          end
          C_IALU: ctrl_o.alu_op = {1'b0, op_i[2:0]};
          C_LD, C_ST: ctrl_o.alu_op = ALU_ADD;
          C_BR: begin
            ctrl_o.alu_op = ALU_SUB;
            ctrl_o.branch = op_i[1:0];
          end
          default: ;
        endcase
        // stack pointer adjust is computed here and committed in MEM
        ctrl_o.spmux   = sp_op;
        ctrl_o.read_sp = sp_op;
        ctrl_o.pm4     = sp_dn;
      end

      S_MEM: begin
        ctrl_o.halt_pc   = 1'b1;
        // keep the SP adder selected so writeSP captures SP+/-1;
        // spmmux steers the memory address from SP for stack ops
        ctrl_o.spmux     = sp_op;
        ctrl_o.spmmux    = sp_op;
        ctrl_o.write_sp  = sp_op;
        ctrl_o.pm4       = sp_dn;
        ctrl_o.mem_read  = (cls == C_LD) || (cls == C_POP) || (cls == C_RET);
        ctrl_o.mem_write = (cls == C_ST) || (cls == C_PUSH) || (cls == C_CALL);
        // CALL stores the return address (PC+1) instead of a register
        ctrl_o.ret_mem   = (cls == C_CALL);
        ctrl_o.update_sp = (cls == C_CALL);
      end

      S_WB: begin
        ctrl_o.pc_update = 1'b1;
        case (cls)
          C_RALU: begin
            ctrl_o.write_reg = 1'b1;
            ctrl_o.reg_dest  = 1'b1;
          end
          C_IALU: ctrl_o.write_reg = 1'b1;
          C_LD, C_POP: begin
            ctrl_o.write_reg = 1'b1;
            ctrl_o.mem_reg   = 1'b1;
          end
          C_MOVE: begin
            ctrl_o.write_reg = 1'b1;
            ctrl_o.move_reg  = 1'b1;
          end
          C_JMP, C_CALL: ctrl_o.jump = 1'b1;
          C_RET: begin
            ctrl_o.ret_pc  = 1'b1;
            ctrl_o.mem_reg = 1'b1;
          end
          C_BR: ctrl_o.branch = op_i[1:0];
          default: ;
        endcase
      end

      S_HALT: begin
        ctrl_o.halt_pc = 1'b1;
        ctrl_o.halted  = 1'b1;
      end

      default: begin
        ctrl_o.halt_pc = 1'b1;
      end
    endcase
  end

endmodule : control_decode
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : control_fsm
// Description : Multi-cycle processor control unit. Sequences
//               FETCH/DECODE/EXEC/[MEM]/WB (or HALT) and drives registered
//               datapath strobes decoded from the next state and held IR.
// Revision    : 1.0 - initial release
// ============================================================================
module control_fsm
  import control_pkg::*;
(
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  input  logic [31:0]       instr,
  output logic              PCUpdate,
  output logic              regDest,
  output logic              writeSP,
  output logic              readSP,
  output logic              updateSP,
  output logic              writeReg,
  output logic              aluSource,
  output logic              PM4,
  output logic              spmmux,
  output logic              retMem,
  output logic              memRead,
  output logic              memWrite,
  output logic              memReg,
  output logic              spmux,
  output logic              moveReg,
  output logic              jump,
  output logic              retPC,
  output logic              haltPC,
  output logic [1:0]        branch,
  output logic [ALUOPW-1:0] aluOp,
  output logic              halted,
  output logic [STW-1:0]    state_o
);

  logic [STW-1:0] state_q, state_d;
  logic           started_q;   // low until the first edge after reset release
  logic [31:0]    ir_q, ir_d;
  ctrl_t          ctrl_q, ctrl_d;
  iclass_e        cls_q;
  logic           unused_ir;

  assign cls_q     = classify(ir_q[31:26]);
  // register-field bits belong to the datapath, not to control
  assign unused_ir = ^ir_q[25:4];

  // Capture the instruction word as the FSM leaves FETCH
  always_comb begin
    ir_d = ir_q;
    if (started_q && (state_q == S_FETCH)) begin
      ir_d = instr;
    end
  end

  // Next-state sequencing; the first edge after reset enters FETCH
  always_comb begin
    state_d = state_q;
    if (!started_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: state_d = (cls_q == C_HALT) ? S_HALT : S_EXEC;
        S_EXEC:   state_d = uses_mem(cls_q) ? S_MEM : S_WB;
        S_MEM:    state_d = S_WB;
        S_WB:     state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Outputs for the state being entered, so they hold for its whole cycle
  control_decode u_decode (
    .state_i (state_d),
    .op_i    (ir_d[31:26]),
    .funct_i (ir_d[3:0]),
    .ctrl_o  (ctrl_d)
  );

  // State, IR and registered control vector; reset clears all immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
      ir_q      <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign PCUpdate  = ctrl_q.pc_update;
  assign regDest   = ctrl_q.reg_dest;
  assign writeSP   = ctrl_q.write_sp;
  assign readSP    = ctrl_q.read_sp;
  assign updateSP  = ctrl_q.update_sp;
  assign writeReg  = ctrl_q.write_reg;
  assign aluSource = ctrl_q.alu_source;
  assign PM4       = ctrl_q.pm4;
  assign spmmux    = ctrl_q.spmmux;
  assign retMem    = ctrl_q.ret_mem;
  assign memRead   = ctrl_q.mem_read;
  assign memWrite  = ctrl_q.mem_write;
  assign memReg    = ctrl_q.mem_reg;
  assign spmux     = ctrl_q.spmux;
  assign moveReg   = ctrl_q.move_reg;
  assign jump      = ctrl_q.jump;
  assign retPC     = ctrl_q.ret_pc;
  assign haltPC    = ctrl_q.halt_pc;
  assign branch    = ctrl_q.branch;
  assign aluOp     = ctrl_q.alu_op;
  assign halted    = ctrl_q.halted;
  assign state_o   = state_q;

endmodule : control_fsm
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_fsm
// Description : Scoreboard bench for control_fsm. Stimulus queues the expected
//               per-cycle control vector from a rule-based model; a monitor
//               pops and compares one entry per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic PCUpdate, regDest, writeSP, readSP, updateSP, writeReg, aluSource, PM4;
  logic spmmux, retMem, memRead, memWrite, memReg, spmux, moveReg, jump, retPC, haltPC;
  logic [1:0]  branch;
  logic [3:0]  aluOp;
  logic        halted;
  logic [2:0]  state_o;

  control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr),
    .PCUpdate(PCUpdate), .regDest(regDest), .writeSP(writeSP), .readSP(readSP),
    .updateSP(updateSP), .writeReg(writeReg), .aluSource(aluSource), .PM4(PM4),
    .spmmux(spmmux), .retMem(retMem), .memRead(memRead), .memWrite(memWrite),
    .memReg(memReg), .spmux(spmux), .moveReg(moveReg), .jump(jump), .retPC(retPC),
    .haltPC(haltPC), .branch(branch), .aluOp(aluOp), .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  logic [27:0] dvec;
  assign dvec = {state_o, halted, branch, aluOp, PCUpdate, regDest, writeSP, readSP,
                 updateSP, writeReg, aluSource, PM4, spmmux, retMem, memRead, memWrite,
                 memReg, spmux, moveReg, jump, retPC, haltPC};

  typedef struct packed {
    logic [27:0] v;
    logic [31:0] ins;
  } item_t;

  item_t sb_q[$];
  int checks    = 0;
  int failures  = 0;
  int retired   = 0;
  int pc_pulses = 0;

  // Expected outputs for one step (st = FETCH 0 .. WB 4, HALT 7) of instruction ins
  function automatic logic [27:0] model(input logic [31:0] ins, input int st);
    logic [5:0] op;
    logic [2:0] s3;
    logic [1:0] brc;
    logic [3:0] alu;
    bit r, i, ld, sw, br, jmp, call, ret, push, pop, mov;
    bit ex, mem, wb, hs, dn, up, sp;
    op   = ins[31:26];
    r    = (op == 6'b000000);
    i    = (op[5:3] == 3'b001);
    ld   = (op == 6'b010000);
    sw   = (op == 6'b010001);
    br   = (op[5:2] == 4'b0101) && (op[1:0] != 2'b00);
    jmp  = (op == 6'b011000);
    call = (op == 6'b011001);
    ret  = (op == 6'b011010);
    push = (op == 6'b011011);
    pop  = (op == 6'b011100);
    mov  = (op == 6'b011101);
    ex   = (st == 2);
    mem  = (st == 3);
    wb   = (st == 4);
    hs   = (st == 7);
    dn   = push || call;
    up   = pop || ret;
    sp   = dn || up;
    brc  = (br && (ex || wb)) ? op[1:0] : 2'b00;
    alu  = 4'b0000;
    if (ex) begin
      if (r)       alu = ins[3:0];
      else if (i)  alu = {1'b0, op[2:0]};
      else if (br) alu = 4'b0001;
    end
    s3 = st[2:0];
    return {s3, hs, brc, alu,
            wb,                              // PCUpdate
            r && (ex || wb),                 // regDest
            mem && sp,                       // writeSP
            ex && sp,                        // readSP
            mem && call,                     // updateSP
            wb && (r || i || ld || pop || mov), // writeReg
            ex && r,                         // aluSource
            (ex || mem) && dn,               // PM4
            mem && sp,                       // spmmux
            mem && call,                     // retMem
            mem && (ld || pop || ret),       // memRead
            mem && (sw || push || call),     // memWrite
            wb && (ld || pop || ret),        // memReg
            (ex || mem) && sp,               // spmux
            wb && mov,                       // moveReg
            wb && (jmp || call),             // jump
            wb && ret,                       // retPC
            !wb};                            // haltPC
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op;
    w  = $urandom();
    op = w[31:26];
    case ($urandom_range(0, 12))
      0:  op = 6'b000000;
      1:  op = {3'b001, op[2:0]};
      2:  op = 6'b010000;
      3:  op = 6'b010001;
      4:  op = {4'b0101, op[1:0]};
      5:  op = 6'b011000;
      6:  op = 6'b011001;
      7:  op = 6'b011010;
      8:  op = 6'b011011;
      9:  op = 6'b011100;
      10: op = 6'b011101;
      11: begin
        op = {1'b1, op[4:0]};
        if (op == 6'b111111) op = 6'b100000;
      end
      default: op = 6'b011110;
    endcase
    w[31:26] = op;
    return w;
  endfunction

  task automatic push_exp(input logic [27:0] v);
    item_t it;
    it.v   = v;
    it.ins = instr;
    sb_q.push_back(it);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Issue one non-HALT instruction; called 1 time unit into its FETCH cycle
  task automatic issue(input logic [31:0] ins);
    int         seq[$];
    logic [5:0] op;
    op    = ins[31:26];
    instr = ins;
    seq.push_back(0);
    seq.push_back(1);
    seq.push_back(2);
    if (op inside {6'b010000, 6'b010001, 6'b011001, 6'b011010, 6'b011011, 6'b011100})
      seq.push_back(3);
    seq.push_back(4);
    foreach (seq[k]) push_exp(model(ins, seq[k]));
    retired++;
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  // Assert reset now, check the asynchronous clear, then release and realign
  task automatic do_reset(input bit push_now, input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_outputs"}, 32'(dvec), 32'd0);
    if (push_now) push_exp('0);
    @(posedge clk);
    #1;
    push_exp('0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one scoreboard entry per cycle plus output invariants
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      checks++;
      if (memRead && memWrite) begin
        failures++;
        $display("FAIL rd_wr_exclusive: memRead=%b memWrite=%b required not both 1", memRead, memWrite);
      end
      checks++;
      if (writeReg && memWrite) begin
        failures++;
        $display("FAIL wreg_wr_exclusive: writeReg=%b memWrite=%b required not both 1", writeReg, memWrite);
      end
      if (PCUpdate) pc_pulses++;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        checks++;
        if (dvec !== it.v) begin
          failures++;
          $display("FAIL scoreboard ins=%h state=%0d got=%h expected=%h",
                   it.ins, state_o, dvec, it.v);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int p0;
    logic [31:0] w;
    reset = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state_o), 32'd0);
    push_exp('0);
    @(posedge clk);
    #1;
    // released but no edge yet: still idle at FETCH code with outputs low
    push_exp('0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // directed: R ADD, LD, BZ, CALL+RET
    w = $urandom();
    issue({6'b000000, w[25:4], 4'b0000});
    w = $urandom();
    issue({6'b010000, w[25:0]});
    w = $urandom();
    issue({6'b010101, w[25:0]});
    p0 = pc_pulses;
    w = $urandom();
    issue({6'b011001, w[25:0]});
    w = $urandom();
    issue({6'b011010, w[25:0]});
    check("call_ret_pcupdate", 32'(pc_pulses - p0), 32'd2);

    for (int n = 0; n < 40; n++) issue(rand_instr());

    // ST interrupted by reset during its MEM cycle
    w = $urandom();
    instr = {6'b010001, w[25:0]};
    for (int k = 0; k < 4; k++) push_exp(model(instr, k));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("st_mem_write", 32'(memWrite), 32'd1);
    p0 = pc_pulses;
    do_reset(1'b0, "rst_mid_mem");
    check("rst_mid_mem_no_pcupdate", 32'(pc_pulses - p0), 32'd0);

    for (int n = 0; n < 10; n++) issue(rand_instr());

    // HALT: sticky for 20 cycles, then reset restarts
    w = $urandom();
    instr = {6'b111111, w[25:0]};
    push_exp(model(instr, 0));
    push_exp(model(instr, 1));
    for (int k = 0; k < 20; k++) push_exp(model(instr, 7));
    p0 = pc_pulses;
    repeat (22) @(posedge clk);
    #1;
    check("halt_no_pcupdate", 32'(pc_pulses - p0), 32'd0);
    do_reset(1'b1, "rst_from_halt");

    w = $urandom();
    issue({6'b000000, w[25:0]});

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("pcupdate_total", 32'(pc_pulses), 32'(retired));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_control_fsm
`default_nettype wire
